// File: rtl/alu_serie.sv
// Bit-serial ALU: one result bit per clock, LSB first, with a registered carry/borrow chain.
// Start/done handshake via inicio/listo; result and flags update only when an operation completes.
module alu_serie #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] numero1,
    input  logic [WIDTH-1:0] numero2,
    input  logic [2:0]       codigo_operacion,
    input  logic             entrada_acarreo,
    output logic [WIDTH-1:0] resultado,
    output logic             acarreo_salida,
    output logic             cero,
    output logic             ocupado,
    output logic             listo,
    output logic [1:0]       estado
);

    // Handshake: inicio is a request sampled only in IDLE or FIN; listo is a
    // one-cycle pulse in FIN marking resultado/acarreo_salida/cero as freshly valid.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_SUMA  = 3'b001;
    localparam logic [2:0] OP_RESTA = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_NOT   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_r;
    logic [2:0]       op;
    logic             chain;
    logic [CW-1:0]    cnt;

    logic             bit_a;
    logic             bit_b;
    logic             bit_r;
    logic             chain_next;
    logic [WIDTH-1:0] res_next;

    assign estado = state;

    // One slice of the 1-bit ALU operating on the current LSBs and the chain bit.
    always_comb begin
        bit_a      = sh_a[0];
        bit_b      = sh_b[0];
        bit_r      = 1'b0;
        chain_next = chain;
        case (op)
            OP_SUMA: begin
                bit_r      = bit_a ^ bit_b ^ chain;
                chain_next = (bit_a & bit_b) | (chain & (bit_a ^ bit_b));
            end
            OP_RESTA: begin
                bit_r      = bit_a ^ bit_b ^ chain;
                chain_next = (~bit_a & (bit_b | chain)) | (bit_b & chain);
            end
            OP_OR:   bit_r = bit_a | bit_b;
            OP_AND:  bit_r = bit_a & bit_b;
            OP_NOT:  bit_r = ~bit_a;
            default: bit_r = 1'b0;
        endcase
        res_next            = sh_r >> 1;
        res_next[WIDTH-1]   = bit_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sh_a           <= '0;
            sh_b           <= '0;
            sh_r           <= '0;
            op             <= 3'b000;
            chain          <= 1'b0;
            cnt            <= '0;
            resultado      <= '0;
            acarreo_salida <= 1'b0;
            cero           <= 1'b1;
            ocupado        <= 1'b0;
            listo          <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    listo <= 1'b0;
                    if (inicio) begin
                        sh_a    <= numero1;
                        sh_b    <= numero2;
                        sh_r    <= '0;
                        op      <= codigo_operacion;
                        chain   <= entrada_acarreo;
                        cnt     <= '0;
                        ocupado <= 1'b1;
                        state   <= CALC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_r  <= res_next;
                    chain <= chain_next;
                    // Counter stops at the last bit instead of wrapping.
                    if (cnt == LAST) begin
                        resultado      <= res_next;
                        acarreo_salida <= (op == OP_SUMA || op == OP_RESTA) ? chain_next : 1'b0;
                        cero           <= (res_next == '0);
                        ocupado        <= 1'b0;
                        listo          <= 1'b1;
                        state          <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ocupado <= 1'b0;
                    listo   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serie.sv
// Bench for alu_serie: cycle-level behavioural model plus directed literal cases,
// random operations with input toggling and back-to-back starts, and a WIDTH=1 truth table.
module tb_alu_serie;

    logic       clk;
    logic       rst;
    logic       inicio;
    logic [7:0] numero1;
    logic [7:0] numero2;
    logic [2:0] codigo_operacion;
    logic       entrada_acarreo;
    logic [7:0] resultado;
    logic       acarreo_salida;
    logic       cero;
    logic       ocupado;
    logic       listo;
    logic [1:0] estado;

    logic       inicio_1;
    logic [0:0] numero1_1;
    logic [0:0] numero2_1;
    logic [2:0] codigo_1;
    logic       acarreo_1;
    logic [0:0] resultado_1;
    logic       acarreo_salida_1;
    logic       cero_1;
    logic       ocupado_1;
    logic       listo_1;
    logic [1:0] estado_1;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    alu_serie #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .numero1(numero1), .numero2(numero2),
        .codigo_operacion(codigo_operacion), .entrada_acarreo(entrada_acarreo),
        .resultado(resultado), .acarreo_salida(acarreo_salida), .cero(cero),
        .ocupado(ocupado), .listo(listo), .estado(estado)
    );

    alu_serie #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .inicio(inicio_1), .numero1(numero1_1), .numero2(numero2_1),
        .codigo_operacion(codigo_1), .entrada_acarreo(acarreo_1),
        .resultado(resultado_1), .acarreo_salida(acarreo_salida_1), .cero(cero_1),
        .ocupado(ocupado_1), .listo(listo_1), .estado(estado_1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference arithmetic ----------------
    // Returns {carry/borrow, result} for a w-bit operation, computed with plain integers.
    function automatic logic [8:0] ref_alu(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic c);
        logic [8:0] mask;
        logic [8:0] t;
        logic [8:0] r;
        logic       co;
        mask = (9'd1 << w) - 9'd1;
        r    = '0;
        co   = 1'b0;
        t    = '0;
        case (op)
            3'b001: begin
                t  = {1'b0, a} + {1'b0, b} + {8'd0, c};
                r  = t & mask;
                co = t[w];
            end
            3'b010: begin
                t  = {1'b0, a} - {1'b0, b} - {8'd0, c};
                r  = t & mask;
                co = ({1'b0, a} < ({1'b0, b} + {8'd0, c}));
            end
            3'b100:  r = {1'b0, a | b} & mask;
            3'b101:  r = {1'b0, a & b} & mask;
            3'b110:  r = {1'b0, ~a} & mask;
            default: r = '0;
        endcase
        return {co, r[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (WIDTH=8) ----------------
    logic [8:0] exp_q[$];
    int         m_rem   = 0;
    bit         m_busy  = 0;
    bit         m_listo = 0;
    logic [7:0] m_res   = '0;
    logic       m_c     = 1'b0;
    logic       m_z     = 1'b1;

    always @(posedge clk) begin
        logic [8:0] v;
        if (rst) begin
            m_rem = 0; m_busy = 0; m_listo = 0;
            m_res = '0; m_c = 1'b0; m_z = 1'b1;
            exp_q.delete();
        end else if (!m_busy && inicio) begin
            exp_q.push_back(ref_alu(8, numero1, numero2, codigo_operacion, entrada_acarreo));
            m_rem   = 8;
            m_busy  = 1;
            m_listo = 0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                v       = exp_q.pop_front();
                m_res   = v[7:0];
                m_c     = v[8];
                m_z     = (v[7:0] == 8'd0);
                m_busy  = 0;
                m_listo = 1;
            end
        end else begin
            m_listo = 0;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("resultado", 32'(resultado), 32'(m_res));
            check("acarreo_salida", 32'(acarreo_salida), 32'(m_c));
            check("cero", 32'(cero), 32'(m_z));
            check("ocupado", 32'(ocupado), 32'(m_busy));
            check("listo", 32'(listo), 32'(m_listo));
        end
    end

    // ---------------- driver tasks ----------------
    // Waits (bounded) for listo; optionally scrambles inputs every CALC cycle.
    task automatic wait_listo(input bit toggle, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!listo && n < 20) begin
            if (ocupado) busy_n++;
            if (toggle) begin
                numero1          = 8'($urandom);
                numero2          = 8'($urandom);
                codigo_operacion = 3'($urandom);
                entrada_acarreo  = 1'($urandom);
                inicio           = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        inicio = 1'b0;
        check("latency", 32'(n), 32'd8);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic c);
        numero1          = a;
        numero2          = b;
        codigo_operacion = op;
        entrada_acarreo  = c;
        inicio           = 1'b1;
        @(negedge clk);
        inicio           = 1'b0;
    endtask

    task automatic op_lit(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic c, input bit toggle,
                          input logic [7:0] exp_r, input logic exp_c);
        int n;
        int busy_n;
        start_op(a, b, op, c);
        wait_listo(toggle, n, busy_n);
        check({name, "_res"}, 32'(resultado), 32'(exp_r));
        check({name, "_carry"}, 32'(acarreo_salida), 32'(exp_c));
        check({name, "_cero"}, 32'(cero), 32'(exp_r == 8'd0));
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         n;
        int         busy_n;
        bit         b2b;
        logic [8:0] e1;

        rst = 1'b1; inicio = 1'b0; numero1 = '0; numero2 = '0;
        codigo_operacion = '0; entrada_acarreo = 1'b0;
        inicio_1 = 1'b0; numero1_1 = '0; numero2_1 = '0; codigo_1 = '0; acarreo_1 = 1'b0;
        @(negedge clk);
        chk_en = 1;
        check("reset_resultado", 32'(resultado), 32'd0);
        check("reset_cero", 32'(cero), 32'd1);
        check("reset_ocupado", 32'(ocupado), 32'd0);
        check("reset_listo", 32'(listo), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Suma overflow, with ocupado width check.
        start_op(8'hFF, 8'h01, 3'b001, 1'b0);
        wait_listo(1'b0, n, busy_n);
        check("suma_ff_res", 32'(resultado), 32'h00);
        check("suma_ff_carry", 32'(acarreo_salida), 32'd1);
        check("suma_ff_cero", 32'(cero), 32'd1);
        check("suma_ff_busy_cycles", 32'(busy_n), 32'd8);
        @(negedge clk);
        check("listo_one_cycle", 32'(listo), 32'd0);

        op_lit("resta_5_7", 8'h05, 8'h07, 3'b010, 1'b0, 1'b0, 8'hFE, 1'b1);
        op_lit("resta_10_0f_b", 8'h10, 8'h0F, 3'b010, 1'b1, 1'b0, 8'h00, 1'b0);
        op_lit("or", 8'hCA, 8'h0F, 3'b100, 1'b1, 1'b0, 8'hCF, 1'b0);
        op_lit("and", 8'hCA, 8'h0F, 3'b101, 1'b1, 1'b0, 8'h0A, 1'b0);
        op_lit("not", 8'hCA, 8'h0F, 3'b110, 1'b1, 1'b0, 8'h35, 1'b0);
        op_lit("code011", 8'hCA, 8'h0F, 3'b011, 1'b1, 1'b0, 8'h00, 1'b0);
        op_lit("toggle_suma", 8'h3C, 8'h5A, 3'b001, 1'b1, 1'b1, 8'h97, 1'b0);

        // Back-to-back: second op accepted in the FIN cycle.
        start_op(8'hCA, 8'h0F, 3'b100, 1'b0);
        wait_listo(1'b0, n, busy_n);
        check("b2b_first_res", 32'(resultado), 32'hCF);
        start_op(8'h10, 8'h20, 3'b001, 1'b0);
        check("b2b_no_idle", 32'(ocupado), 32'd1);
        check("b2b_hold_res", 32'(resultado), 32'hCF);
        wait_listo(1'b0, n, busy_n);
        check("b2b_listo_gap", 32'(n + 1), 32'd9);
        check("b2b_second_res", 32'(resultado), 32'h30);
        @(negedge clk);

        // Reset in the 4th CALC cycle.
        start_op(8'h7F, 8'h01, 3'b001, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_resultado", 32'(resultado), 32'd0);
        check("midrst_carry", 32'(acarreo_salida), 32'd0);
        check("midrst_cero", 32'(cero), 32'd1);
        check("midrst_ocupado", 32'(ocupado), 32'd0);
        check("midrst_listo", 32'(listo), 32'd0);
        @(negedge clk);
        op_lit("after_rst_suma", 8'h7F, 8'h01, 3'b001, 1'b0, 1'b0, 8'h80, 1'b0);

        // Random operations, sometimes back-to-back, sometimes with scrambled inputs.
        for (int i = 0; i < 150; i++) begin
            start_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
            wait_listo(1'($urandom_range(0, 1)), n, busy_n);
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // WIDTH=1 slice: every code against every operand/carry combination.
        for (int oi = 0; oi < 5; oi++) begin
            logic [2:0] ops [5];
            ops = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
            for (int v = 0; v < 8; v++) begin
                numero1_1 = 1'(v);
                numero2_1 = 1'(v >> 1);
                acarreo_1 = 1'(v >> 2);
                codigo_1  = ops[oi];
                e1 = ref_alu(1, {7'd0, numero1_1}, {7'd0, numero2_1}, codigo_1, acarreo_1);
                inicio_1  = 1'b1;
                @(negedge clk);
                inicio_1  = 1'b0;
                check("w1_ocupado", 32'(ocupado_1), 32'd1);
                check("w1_listo_early", 32'(listo_1), 32'd0);
                @(negedge clk);
                check("w1_listo", 32'(listo_1), 32'd1);
                check("w1_res", 32'(resultado_1), 32'(e1[0]));
                check("w1_carry", 32'(acarreo_salida_1), 32'(e1[8]));
                check("w1_cero", 32'(cero_1), 32'(e1[0] == 1'b0));
                @(negedge clk);
                check("w1_listo_drop", 32'(listo_1), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
